// File: rtl/postfix_eval_ctrl_if.sv
// Token stream and result/status bundle between the postfix token source
// (master) and the postfix evaluation controller (slave).
interface postfix_eval_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             tok_valid;
    logic             tok_ready;
    logic [WIDTH-1:0] tok_data;
    logic             tok_is_op;
    logic             tok_last;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             error;
    logic [2:0]       err_code;

    modport master (
        output start, tok_valid, tok_data, tok_is_op, tok_last,
        input  tok_ready, busy, result, result_valid, error, err_code
    );

    modport slave (
        input  start, tok_valid, tok_data, tok_is_op, tok_last,
        output tok_ready, busy, result, result_valid, error, err_code
    );
endinterface

// File: rtl/postfix_eval_ctrl.sv
// Postfix expression evaluator: owns the operand stack and sequences
// fetch / pop B / pop A / execute / push for each operator, then reports
// either the single remaining stack value or an error code.
// Optional signed divide ('/', code 47) is built when POSTFIX_EVAL_DIV_EN
// is defined; otherwise '/' is rejected as a bad operator.
module postfix_eval_ctrl #(
    parameter int DEPTH = 13,
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    postfix_eval_ctrl_if.slave bus
);
    localparam int               SP_W    = $clog2(DEPTH + 1);
    localparam logic [SP_W-1:0]  SP_FULL = SP_W'(DEPTH);
    localparam logic [SP_W-1:0]  SP_ONE  = SP_W'(1);
    localparam logic [WIDTH-1:0] OP_MUL  = WIDTH'(42);
    localparam logic [WIDTH-1:0] OP_ADD  = WIDTH'(43);
    localparam logic [WIDTH-1:0] OP_SUB  = WIDTH'(45);

    typedef enum logic [2:0] {
        IDLE, FETCH, POP_B, POP_A, EXEC, FINISH, DRAIN
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_OVERFLOW  = 3'd1,
        ERR_UNDERFLOW = 3'd2,
        ERR_BAD_OP    = 3'd3,
        ERR_DEPTH     = 3'd4,
        ERR_DIV_ZERO  = 3'd5
    } err_t;

    state_t           state;
    logic [SP_W-1:0]  sp;
    // NOTE: the stack is plain storage with no reset; sp alone defines which
    // entries are live, so clearing the array would only cost flops.
    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] opcode;
    logic             last_q;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    logic [WIDTH-1:0] exec_val;
    logic             exec_ok;
    logic             exec_done;
    logic             fault;
    err_t             fault_code;
    logic             fault_last;

`ifdef POSTFIX_EVAL_DIV_EN
    localparam int               CNT_W  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] OP_DIV = WIDTH'(47);

    logic             div_run;
    logic             div_neg;
    logic [CNT_W-1:0] div_cnt;
    logic [WIDTH-1:0] div_den;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_quo_nxt;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // One restoring-division step on the operand magnitudes.
    always_comb begin
        div_shift   = {div_rem, div_quo[WIDTH-1]};
        div_diff    = div_shift - {1'b0, div_den};
        div_ge      = div_shift >= {1'b0, div_den};
        div_rem_nxt = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_nxt = {div_quo[WIDTH-2:0], div_ge};
    end
`endif

    // Operator decode and ALU result; products and sums wrap modulo 2^WIDTH.
    always_comb begin
        exec_ok   = 1'b1;
        exec_done = 1'b1;
        exec_val  = '0;
        case (opcode)
            OP_ADD: exec_val = opa + opb;
            OP_SUB: exec_val = opa - opb;
            OP_MUL: exec_val = opa * opb;
`ifdef POSTFIX_EVAL_DIV_EN
            OP_DIV: begin
                exec_done = div_run && (div_cnt == CNT_W'(1));
                exec_val  = div_neg ? (~div_quo_nxt + WIDTH'(1)) : div_quo_nxt;
            end
`endif
            default: exec_ok = 1'b0;
        endcase
    end

    // Error detection for the current state; fault_last says whether the
    // stream's final token has already been consumed (exit to IDLE, not DRAIN).
    always_comb begin
        fault      = 1'b0;
        fault_code = ERR_NONE;
        fault_last = last_q;
        case (state)
            FETCH: begin
                if (bus.tok_valid && !bus.tok_is_op && sp == SP_FULL) begin
                    fault      = 1'b1;
                    fault_code = ERR_OVERFLOW;
                    fault_last = bus.tok_last;
                end
            end
            POP_B, POP_A: begin
                if (sp == '0) begin
                    fault      = 1'b1;
                    fault_code = ERR_UNDERFLOW;
                end
            end
            EXEC: begin
                if (!exec_ok) begin
                    fault      = 1'b1;
                    fault_code = ERR_BAD_OP;
                end
`ifdef POSTFIX_EVAL_DIV_EN
                else if (opcode == OP_DIV && !div_run && opb == '0) begin
                    fault      = 1'b1;
                    fault_code = ERR_DIV_ZERO;
                end
`endif
            end
            FINISH: begin
                if (sp != SP_ONE) begin
                    fault      = 1'b1;
                    fault_code = ERR_DEPTH;
                    fault_last = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sequencer: state, stack, and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            sp               <= '0;
            last_q           <= 1'b0;
            bus.tok_ready    <= 1'b0;
            bus.busy         <= 1'b0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.error        <= 1'b0;
            bus.err_code     <= ERR_NONE;
`ifdef POSTFIX_EVAL_DIV_EN
            div_run          <= 1'b0;
`endif
        end else begin
            bus.result_valid <= 1'b0;
            bus.error        <= 1'b0;
            if (fault) begin
                bus.error     <= 1'b1;
                bus.err_code  <= fault_code;
                sp            <= '0;
                state         <= fault_last ? IDLE : DRAIN;
                bus.tok_ready <= !fault_last;
                bus.busy      <= !fault_last;
`ifdef POSTFIX_EVAL_DIV_EN
                div_run       <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state         <= FETCH;
                            sp            <= '0;
                            bus.err_code  <= ERR_NONE;
                            bus.tok_ready <= 1'b1;
                            bus.busy      <= 1'b1;
                        end
                    end
                    FETCH: begin
                        if (bus.tok_valid) begin
                            if (bus.tok_is_op) begin
                                opcode        <= bus.tok_data;
                                last_q        <= bus.tok_last;
                                state         <= POP_B;
                                bus.tok_ready <= 1'b0;
                            end else begin
                                stack[sp] <= bus.tok_data;
                                sp        <= sp + SP_ONE;
                                if (bus.tok_last) begin
                                    state         <= FINISH;
                                    bus.tok_ready <= 1'b0;
                                end
                            end
                        end
                    end
                    POP_B: begin
                        opb   <= stack[sp - SP_ONE];
                        sp    <= sp - SP_ONE;
                        state <= POP_A;
                    end
                    POP_A: begin
                        opa   <= stack[sp - SP_ONE];
                        sp    <= sp - SP_ONE;
                        state <= EXEC;
                    end
                    EXEC: begin
`ifdef POSTFIX_EVAL_DIV_EN
                        if (opcode == OP_DIV && !div_run) begin
                            div_run <= 1'b1;
                            div_neg <= opa[WIDTH-1] ^ opb[WIDTH-1];
                            div_cnt <= CNT_W'(WIDTH);
                            div_den <= mag(opb);
                            div_quo <= mag(opa);
                            div_rem <= '0;
                        end else if (div_run) begin
                            div_rem <= div_rem_nxt;
                            div_quo <= div_quo_nxt;
                            div_cnt <= div_cnt - CNT_W'(1);
                            if (exec_done) div_run <= 1'b0;
                        end
`endif
                        if (exec_done) begin
                            stack[sp]     <= exec_val;
                            sp            <= sp + SP_ONE;
                            state         <= last_q ? FINISH : FETCH;
                            bus.tok_ready <= !last_q;
                        end
                    end
                    FINISH: begin
                        bus.result       <= stack[0];
                        bus.result_valid <= 1'b1;
                        sp               <= '0;
                        state            <= IDLE;
                        bus.busy         <= 1'b0;
                    end
                    DRAIN: begin
                        if (bus.tok_valid && bus.tok_last) begin
                            state         <= IDLE;
                            bus.tok_ready <= 1'b0;
                            bus.busy      <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_postfix_eval_ctrl.sv
// Self-checking bench for postfix_eval_ctrl: directed expressions plus
// randomized token streams, each scored against a queue-based postfix model.
module tb_postfix_eval_ctrl;
    localparam int DEPTH = 13;
    localparam int WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             is_op;
    } tok_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    int               n_rv = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] rv_val = '0;
    logic [2:0]       err_seen = '0;
    int               pulse_cyc = 0;
    int               hs_cyc = 0;
    logic [WIDTH-1:0] last_result;
    logic [2:0]       last_code;

    postfix_eval_ctrl_if #(.WIDTH(WIDTH)) bus ();

    postfix_eval_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.result_valid) begin
            n_rv      <= n_rv + 1;
            rv_val    <= bus.result;
            pulse_cyc <= cyc;
        end
        if (bus.error) begin
            n_err    <= n_err + 1;
            err_seen <= bus.err_code;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic tok_t opnd(input int v);
        tok_t t;
        t.data  = WIDTH'(v);
        t.is_op = 1'b0;
        return t;
    endfunction

    function automatic tok_t oper(input int c);
        tok_t t;
        t.data  = WIDTH'(c);
        t.is_op = 1'b1;
        return t;
    endfunction

    function automatic int wrap(input int r);
        logic signed [WIDTH-1:0] t;
        t = r[WIDTH-1:0];
        return int'(t);
    endfunction

    // Reference: evaluate the postfix stream with an integer stack.
    function automatic void model(input tok_t toks[$], output logic exp_err,
                                  output logic [2:0] exp_code, output logic [WIDTH-1:0] exp_val);
        int st[$];
        int a, b, r;
        exp_err  = 1'b0;
        exp_code = 3'd0;
        exp_val  = '0;
        foreach (toks[i]) begin
            if (!toks[i].is_op) begin
                if (st.size() == DEPTH) begin exp_err = 1'b1; exp_code = 3'd1; return; end
                st.push_back(int'($signed(toks[i].data)));
            end else begin
                if (st.size() == 0) begin exp_err = 1'b1; exp_code = 3'd2; return; end
                b = st.pop_back();
                if (st.size() == 0) begin exp_err = 1'b1; exp_code = 3'd2; return; end
                a = st.pop_back();
                case (int'(toks[i].data))
                    43: r = a + b;
                    45: r = a - b;
                    42: r = a * b;
`ifdef POSTFIX_EVAL_DIV_EN
                    47: begin
                        if (b == 0) begin exp_err = 1'b1; exp_code = 3'd5; return; end
                        r = a / b;
                    end
`endif
                    default: begin exp_err = 1'b1; exp_code = 3'd3; return; end
                endcase
                st.push_back(wrap(r));
            end
        end
        if (st.size() != 1) begin exp_err = 1'b1; exp_code = 3'd4; return; end
        exp_val = WIDTH'(st[0]);
    endfunction

    task automatic do_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_tok(input tok_t t, input logic last);
        int   waited;
        logic rdy;
        bus.tok_data  = t.data;
        bus.tok_is_op = t.is_op;
        bus.tok_last  = last;
        bus.tok_valid = 1'b1;
        waited = 0;
        rdy    = 1'b0;
        while (!rdy && waited < 64) begin
            @(negedge clk);
            rdy = bus.tok_ready;
            waited++;
        end
        if (!rdy) check("tok_ready_wait", {31'd0, rdy}, 32'd1);
        else hs_cyc = cyc + 1;
        @(posedge clk); #1;
        bus.tok_valid = 1'b0;
    endtask

    task automatic run_expr(input tok_t toks[$]);
        logic             e;
        logic [2:0]       c;
        logic [WIDTH-1:0] v;
        int               rv0, er0, waited;
        tok_t             tl;
        model(toks, e, c, v);
        rv0 = n_rv;
        er0 = n_err;
        do_start();
        foreach (toks[i]) begin
            send_tok(toks[i], i == toks.size() - 1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (bus.busy && waited < 200);
        check("busy_drop", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        last_result = rv_val;
        last_code   = bus.err_code;
        tl          = toks[toks.size() - 1];
        check("pulse_count", (n_rv - rv0) + (n_err - er0), 1);
        if (e) begin
            check("err_pulse", n_err - er0, 1);
            check("err_code_pulse", {29'd0, err_seen}, {29'd0, c});
            check("err_code_hold", {29'd0, bus.err_code}, {29'd0, c});
        end else begin
            check("result", {16'd0, rv_val}, {16'd0, v});
            check("result_hold", {16'd0, bus.result}, {16'd0, v});
            check("err_code_clear", {29'd0, bus.err_code}, 32'd0);
            if (!(tl.is_op && tl.data == WIDTH'(47)))
                check("latency", pulse_cyc - hs_cyc, tl.is_op ? 4 : 1);
        end
        check("ready_idle", {31'd0, bus.tok_ready}, 32'd0);
    endtask

    task automatic gen_expr(output tok_t q[$]);
        int   n, depth, sel;
        tok_t t;
        q     = {};
        n     = $urandom_range(1, 16);
        depth = 0;
        for (int i = 0; i < n; i++) begin
            if ((depth >= 2 && $urandom_range(0, 1) == 1) || $urandom_range(0, 11) == 0) begin
                sel = $urandom_range(0, 19);
                if (sel < 6)       t = oper(43);
                else if (sel < 12) t = oper(45);
                else if (sel < 17) t = oper(42);
                else if (sel == 17) t = oper(47);
                else if (sel == 18) t = oper(40);
                else               t = oper($urandom_range(0, 127));
                depth = (depth > 0) ? depth - 1 : 0;
            end else begin
                if ($urandom_range(0, 3) == 0) t = opnd($urandom);
                else                           t = opnd(int'($urandom_range(0, 20)) - 10);
                depth++;
            end
            q.push_back(t);
        end
        if ($urandom_range(0, 3) != 0) begin
            while (depth > 1 && q.size() < 24) begin
                q.push_back(oper(($urandom_range(0, 1) == 1) ? 43 : 42));
                depth--;
            end
        end
    endtask

    initial begin
        tok_t q[$];
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.tok_valid = 1'b0;
        bus.tok_data  = '0;
        bus.tok_is_op = 1'b0;
        bus.tok_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tok_ready", {31'd0, bus.tok_ready}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_result", {16'd0, bus.result}, 32'd0);
        check("rst_result_valid", {31'd0, bus.result_valid}, 32'd0);
        check("rst_error", {31'd0, bus.error}, 32'd0);
        check("rst_err_code", {29'd0, bus.err_code}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        q = {opnd(3), opnd(4), oper(43), opnd(2), oper(42)};
        run_expr(q);
        check("t1_value", {16'd0, last_result}, 32'd14);

        q = {opnd(5), opnd(9), oper(45)};
        run_expr(q);
        check("t2_sub", {16'd0, last_result}, 32'h0000_FFFC);
        q = {opnd(300), opnd(300), oper(42)};
        run_expr(q);
        check("t2_mul_wrap", {16'd0, last_result}, 32'd24464);

        q = {opnd(7), oper(43), opnd(1)};
        run_expr(q);
        check("t3_code", {29'd0, last_code}, 32'd2);

        q = {opnd(1), opnd(2)};
        run_expr(q);
        check("t4_depth_code", {29'd0, last_code}, 32'd4);
        q = {};
        for (int i = 1; i <= 15; i++) q.push_back(opnd(i));
        run_expr(q);
        check("t4_overflow_code", {29'd0, last_code}, 32'd1);

        q = {opnd(1), opnd(2), oper(40)};
        run_expr(q);
        check("t5_bad_op_code", {29'd0, last_code}, 32'd3);
        q = {opnd(6), opnd(2), oper(41), opnd(4), oper(43)};
        run_expr(q);

        // Abort mid-expression with reset.
        do_start();
        send_tok(opnd(8), 1'b0);
        send_tok(opnd(9), 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_tok_ready", {31'd0, bus.tok_ready}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_result", {16'd0, bus.result}, 32'd0);
        check("midrst_result_valid", {31'd0, bus.result_valid}, 32'd0);
        check("midrst_error", {31'd0, bus.error}, 32'd0);
        check("midrst_err_code", {29'd0, bus.err_code}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q = {opnd(2), opnd(3), oper(43)};
        run_expr(q);
        check("t5_after_reset", {16'd0, last_result}, 32'd5);

        q = {opnd(7), opnd(-2), oper(47)};
        run_expr(q);
`ifdef POSTFIX_EVAL_DIV_EN
        check("t6_div", {16'd0, last_result}, 32'h0000_FFFD);
        q = {opnd(7), opnd(0), oper(47)};
        run_expr(q);
        check("t6_div_zero", {29'd0, last_code}, 32'd5);
        q = {opnd(-32768), opnd(-1), oper(47)};
        run_expr(q);
        check("t6_div_min", {16'd0, last_result}, 32'h0000_8000);
`else
        check("t6_no_div", {29'd0, last_code}, 32'd3);
`endif

        for (int n = 0; n < 80; n++) begin
            gen_expr(q);
            run_expr(q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
